// File: rtl/demux_1to8_deser.sv
// rtl/demux_1to8_deser.sv - serial-to-parallel 1:8 frame deserializer with sync resync and idle timeout
module demux_1to8_deser #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_sync,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic h,
    output logic sel0,
    output logic sel1,
    output logic sel2,
    output logic out_valid,
    output logic frame_err
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [7:0] TO_CYCLES = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] slot, slot_nxt;
    logic [6:0] shadow, shadow_nxt;
    logic [7:0] frame, frame_nxt;
    logic [7:0] idle_cnt, idle_cnt_nxt;
    logic       ov_nxt, fe_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot      <= '0;
            shadow    <= '0;
            frame     <= '0;
            idle_cnt  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            shadow    <= shadow_nxt;
            frame     <= frame_nxt;
            idle_cnt  <= idle_cnt_nxt;
            out_valid <= ov_nxt;
            frame_err <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        shadow_nxt   = shadow;
        frame_nxt    = frame;
        idle_cnt_nxt = idle_cnt;
        ov_nxt       = 1'b0;
        fe_nxt       = 1'b0;
        if (in_valid) begin
            idle_cnt_nxt = '0;
            if (state == FILL && in_sync) begin
                // resync: the current bit becomes slot 0 of a fresh frame
                fe_nxt     = 1'b1;
                shadow_nxt = {6'b0, in_bit};
                slot_nxt   = 3'd1;
                state_nxt  = FILL;
            end else if (slot == 3'd7) begin
                frame_nxt  = {in_bit, shadow};
                ov_nxt     = 1'b1;
                shadow_nxt = '0;
                slot_nxt   = '0;
                state_nxt  = IDLE;
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (slot == 3'(i)) shadow_nxt[i] = in_bit;
                end
                slot_nxt  = slot + 3'd1;
                state_nxt = FILL;
            end
        end else if (state == FILL) begin
            if (idle_cnt + 8'd1 == TO_CYCLES) begin
                fe_nxt       = 1'b1;
                shadow_nxt   = '0;
                slot_nxt     = '0;
                idle_cnt_nxt = '0;
                state_nxt    = IDLE;
            end else begin
                idle_cnt_nxt = idle_cnt + 8'd1;
            end
        end
    end

    assign {h, g, f, e, d, c, b, a} = frame;
    assign {sel2, sel1, sel0}       = slot;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// tb/tb_demux_1to8_deser.sv - directed and randomized checks of demux_1to8_deser against a queue model
module tb_demux_1to8_deser;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_bit, in_sync;
    logic a, b, c, d, e, f, g, h, sel0, sel1, sel2, out_valid, frame_err;

    int tests = 0;
    int fails = 0;

    bit         q[$];
    int         idle;
    logic [7:0] exp_frame;
    logic       exp_ov, exp_fe;
    int         nov, nfe, cyc, ov_last, ov_prev;

    always #5 clk = ~clk;

    demux_1to8_deser #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sync(in_sync),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sel0(sel0), .sel1(sel1), .sel2(sel2),
        .out_valid(out_valid), .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] dframe();
        return {h, g, f, e, d, c, b, a};
    endfunction

    function automatic logic [7:0] dsel();
        return {5'b0, sel2, sel1, sel0};
    endfunction

    task automatic model_reset();
        q.delete();
        idle      = 0;
        exp_frame = '0;
        exp_ov    = 1'b0;
        exp_fe    = 1'b0;
    endtask

    // Frame = the list of bits accepted since the last frame boundary.
    task automatic model(input logic v, input logic bb, input logic s);
        exp_ov = 1'b0;
        exp_fe = 1'b0;
        if (v) begin
            if (s && q.size() > 0) begin
                exp_fe = 1'b1;
                q.delete();
            end
            q.push_back(bb);
            idle = 0;
            if (q.size() == 8) begin
                for (int i = 0; i < 8; i++) exp_frame[i] = q[i];
                exp_ov = 1'b1;
                q.delete();
            end
        end else if (q.size() > 0) begin
            idle++;
            if (idle == TO) begin
                exp_fe = 1'b1;
                q.delete();
                idle = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("frame", dframe(), exp_frame);
        chk("sel", dsel(), 8'(q.size()));
        chk("out_valid", {7'b0, out_valid}, {7'b0, exp_ov});
        chk("frame_err", {7'b0, frame_err}, {7'b0, exp_fe});
    endtask

    task automatic step(input logic v, input logic bb, input logic s);
        @(negedge clk);
        in_valid = v;
        in_bit   = bb;
        in_sync  = s;
        @(posedge clk);
        model(v, bb, s);
        #1;
        check_all();
        cyc++;
        nov += int'(out_valid);
        nfe += int'(frame_err);
        if (out_valid) begin
            ov_prev = ov_last;
            ov_last = cyc;
        end
    endtask

    task automatic send_byte(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int         r;
        int         n;
        cyc = 0; ov_last = 0; ov_prev = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_frame", dframe(), 8'h00);
        chk("reset_sel", dsel(), 8'h00);
        chk("reset_flags", {6'b0, out_valid, frame_err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,0,1,1,0,0,1,0 into a..h
        nov = 0; nfe = 0;
        send_byte(8'h4D);
        chk("r033_frame", dframe(), 8'h4D);
        chk("r033_pulses", 8'(nov), 8'd1);
        chk("r033_sel", dsel(), 8'h00);

        nov = 0;
        send_byte(8'hFF);
        chk("r034_ff", dframe(), 8'hFF);
        send_byte(8'h00);
        chk("r034_00", dframe(), 8'h00);
        chk("r034_pulses", 8'(nov), 8'd2);
        chk("r034_spacing", 8'(ov_last - ov_prev), 8'd8);

        nov = 0; nfe = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        chk("r035_frame", dframe(), 8'h01);
        chk("r035_err", 8'(nfe), 8'd1);
        chk("r035_ov", 8'(nov), 8'd1);

        nfe = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0);
        chk("r036_no_err_early", 8'(nfe), 8'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("r036_err_pulse", {7'b0, frame_err}, 8'd1);
        chk("r036_sel", dsel(), 8'h00);
        chk("r036_frame", dframe(), 8'h01);

        nfe = 0; nov = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("r037_err", 8'(nfe), 8'd0);
        chk("r037_ov", 8'(nov), 8'd1);
        chk("r037_frame", dframe(), 8'hFF);

        nfe = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("r038_async_frame", dframe(), 8'h00);
        chk("r038_async_sel", dsel(), 8'h00);
        chk("r038_async_flags", {6'b0, out_valid, frame_err}, 8'h00);
        pat = 8'hA5;
        in_valid = 1'b1; in_bit = pat[0]; in_sync = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        model(1'b1, pat[0], 1'b0);
        #1;
        check_all();
        nfe += int'(frame_err);
        for (int i = 1; i < 8; i++) step(1'b1, pat[i], 1'b0);
        chk("r038_frame", dframe(), 8'hA5);
        chk("r038_err", 8'(nfe), 8'd0);

        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                n = $urandom_range(TO - 2, TO + 2);
                for (int j = 0; j < n; j++) step(1'b0, 1'($urandom), 1'($urandom));
            end else begin
                step(1'(r < 14), 1'($urandom), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
